// File: rtl/mem_dp_pkg.sv
// Shared types and constants for the dual-port memory block.
package mem_dp_pkg;

    // Controller states: zero-fill sweep after reset, then normal service.
    typedef enum logic {
        MEM_INIT,
        MEM_READY
    } mem_state_t;

    // Supported read-latency range, in cycles from request edge to valid.
    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid/data. A data stage only loads
// when a valid word moves into it, so the output word holds between reads.
module mem_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [RD_LAT-1:0] valid_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    // Shift read requests toward the output; reset discards in-flight reads.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= i_valid;
            if (i_valid) begin
                data_q[0] <= i_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign o_valid = valid_q[RD_LAT-1];
    assign o_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/memory_dp.sv
// True dual-port synchronous memory with a zero-fill sweep after reset,
// port-A-wins write/write arbitration and selectable read-during-write data.
module memory_dp
    import mem_dp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_ready,
    input  logic              i_a_en,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    output logic [DATA_W-1:0] o_a_data,
    output logic              o_a_valid,
    input  logic              i_b_en,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic [DATA_W-1:0] o_b_data,
    output logic              o_b_valid,
    output logic              o_wr_collision
);

    localparam int DEPTH = 1 << ADDR_W;
    // Terminal sweep count; the counter is one bit wider than an address.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    if (RD_LAT < MIN_RD_LAT || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
        $error("memory_dp: RD_LAT must be within 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_t      state;
    mem_state_t      state_next;
    logic [ADDR_W:0] init_cnt;

    logic              accept;
    logic              a_rd;
    logic              a_wr;
    logic              b_rd;
    logic              b_wr;
    logic              same_addr;
    logic              wr_wr_hit;
    logic              b_wr_keep;
    logic [DATA_W-1:0] a_rd_data;
    logic [DATA_W-1:0] b_rd_data;

    // Requests only count once the sweep has finished.
    assign accept    = (state == MEM_READY);
    assign o_ready   = accept;
    assign a_rd      = accept & i_a_en & ~i_a_we;
    assign a_wr      = accept & i_a_en &  i_a_we;
    assign b_rd      = accept & i_b_en & ~i_b_we;
    assign b_wr      = accept & i_b_en &  i_b_we;
    assign same_addr = (i_a_addr == i_b_addr);
    assign wr_wr_hit = a_wr & b_wr & same_addr;
    assign b_wr_keep = b_wr & ~wr_wr_hit;

    // State register and sweep counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= MEM_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == MEM_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Next state: leave INIT on the edge that clears the last word.
    // NOTE: assigning the default before the case keeps this purely
    // combinational; a path that skipped the assignment would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            MEM_INIT:  if (init_cnt == LAST_IDX) state_next = MEM_READY;
            MEM_READY: state_next = MEM_READY;
            default:   state_next = MEM_INIT;
        endcase
    end

    // Array writes: zero-fill during the sweep, port writes afterwards.
    // Port A wins a same-address write/write; port B's word is dropped.
    // NOTE: the array carries no reset; the sweep clears it, which keeps it
    // mappable onto RAM macros instead of thousands of resettable flops.
    always_ff @(posedge i_clk) begin
        if (state == MEM_INIT) begin
            mem[init_cnt[ADDR_W-1:0]] <= '0;
        end else begin
            if (a_wr) begin
                mem[i_a_addr] <= i_a_data;
            end
            if (b_wr_keep) begin
                mem[i_b_addr] <= i_b_data;
            end
        end
    end

    // Port A read word; write-first mode forwards port B's same-cycle write.
    always_comb begin
        a_rd_data = mem[i_a_addr];
        if (RDW_MODE != 0 && b_wr && same_addr) begin
            a_rd_data = i_b_data;
        end
    end

    // Port B read word; write-first mode forwards port A's same-cycle write.
    always_comb begin
        b_rd_data = mem[i_b_addr];
        if (RDW_MODE != 0 && a_wr && same_addr) begin
            b_rd_data = i_a_data;
        end
    end

    // Flag a same-address write/write one cycle after it happens.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_collision <= 1'b0;
        end else begin
            o_wr_collision <= wr_wr_hit;
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_a_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (a_rd),
        .i_data  (a_rd_data),
        .o_valid (o_a_valid),
        .o_data  (o_a_data)
    );

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_b_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (b_rd),
        .i_data  (b_rd_data),
        .o_valid (o_b_valid),
        .o_data  (o_b_data)
    );

endmodule
